uart_cmd_decoder: RTL

//  Byte-level command parser between the UART receiver/transmitter and the config

---
 rtl/uart_cmd_decoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Byte-level command parser that sits between a UART receiver/transmitter
//   and the configuration register file. Incoming byte frames are turned into
//   single-cycle register write/read strobes. Read data goes back as one TX byte.
//     write frame : 0x57 'W', ADDR, DATA
//     read frame  : 0x52 'R', ADDR
//
//   Optional feature macro: UART_CMD_WRACK_EN
//     defined     - every write frame is acknowledged with one TX byte 0x06
//     not defined - write frames produce no TX traffic
//
// Ports
//   sysclk        in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   rx_data       in   [7:0] received byte, valid while rx_valid is high
//   rx_valid      in   one-cycle strobe per received byte
//   tx_busy       in   UART transmitter busy
//   tx_data       out  [7:0] byte to transmit
//   tx_start      out  one-cycle transmit request
//   uart_reg      out  [7:0] register address
//   uart_dbus_in  out  [7:0] register write data
//   uart_dbus_w   out  one-cycle write strobe
//   uart_dbus_r   out  one-cycle read strobe
//   uart_dbus_out in   [7:0] register read data (combinational from the register file)
//   err_cnt       out  [7:0] saturating protocol error count
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] uart_reg,
  output logic [7:0] uart_dbus_in,
  output logic       uart_dbus_w,
  output logic       uart_dbus_r,
  input  logic [7:0] uart_dbus_out,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
`ifdef UART_CMD_WRACK_EN
  localparam logic [7:0] ACK_BYTE  = 8'h06;
`endif
  // The timeout fires on the edge that ends the TIMEOUT_CYCLES-th idle cycle,
  // i.e. when the counter already holds TIMEOUT_CYCLES-1.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    TX_REQ,
    TX_WAIT
  } state_t;

  state_t               state, state_nxt;
  logic                 op_write, op_write_nxt;
  logic                 busy_seen, busy_seen_nxt;
  logic [TIMEOUT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]           uart_reg_nxt;
  logic [7:0]           dbus_in_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 tx_start_nxt;
  logic                 err_inc;

  // State register.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered datapath and outputs. The read/write strobes are derived from
  // the next state so they are high exactly while the FSM sits in WRITE/READ.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      op_write     <= 1'b0;
      busy_seen    <= 1'b0;
      tmo_cnt      <= '0;
      uart_reg     <= 8'h00;
      uart_dbus_in <= 8'h00;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      uart_dbus_w  <= 1'b0;
      uart_dbus_r  <= 1'b0;
      err_cnt      <= 8'h00;
    end else begin
      op_write     <= op_write_nxt;
      busy_seen    <= busy_seen_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      uart_reg     <= uart_reg_nxt;
      uart_dbus_in <= dbus_in_nxt;
      tx_data      <= tx_data_nxt;
      tx_start     <= tx_start_nxt;
      uart_dbus_w  <= (state_nxt == WRITE);
      uart_dbus_r  <= (state_nxt == READ);
      if (err_inc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Next-state and next-output logic. The inter-byte timeout counter defaults
  // to zero, so it only runs while waiting for ADDR or DATA with no byte present;
  // a byte arriving on the expiry cycle therefore wins over the timeout.
  always_comb begin
    state_nxt     = state;
    op_write_nxt  = op_write;
    busy_seen_nxt = busy_seen;
    tmo_cnt_nxt   = '0;
    uart_reg_nxt  = uart_reg;
    dbus_in_nxt   = uart_dbus_in;
    tx_data_nxt   = tx_data;
    tx_start_nxt  = 1'b0;
    err_inc       = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE) begin
            op_write_nxt = 1'b1;
            state_nxt    = GET_ADDR;
          end else if (rx_data == CMD_READ) begin
            op_write_nxt = 1'b0;
            state_nxt    = GET_ADDR;
          end else begin
            err_inc = 1'b1;
          end
        end
      end

      GET_ADDR: begin
        if (rx_valid) begin
          uart_reg_nxt = rx_data;
          state_nxt    = op_write ? GET_DATA : READ;
        end else if (tmo_cnt == TIMEOUT_LAST) begin
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end

      GET_DATA: begin
        if (rx_valid) begin
          dbus_in_nxt = rx_data;
          state_nxt   = WRITE;
        end else if (tmo_cnt == TIMEOUT_LAST) begin
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end

      WRITE: begin
        if (rx_valid) err_inc = 1'b1;
`ifdef UART_CMD_WRACK_EN
        tx_data_nxt = ACK_BYTE;
        state_nxt   = TX_REQ;
`else
        state_nxt   = IDLE;
`endif
      end

      // The register file answers combinationally while uart_dbus_r is high,
      // which is exactly this cycle.
      READ: begin
        if (rx_valid) err_inc = 1'b1;
        tx_data_nxt = uart_dbus_out;
        state_nxt   = TX_REQ;
      end

      TX_REQ: begin
        if (rx_valid) err_inc = 1'b1;
        if (!tx_busy) begin
          tx_start_nxt  = 1'b1;
          busy_seen_nxt = 1'b0;
          state_nxt     = TX_WAIT;
        end
      end

      // Wait for the transmitter to pick up the byte (busy rises) and finish
      // it (busy falls) before accepting a new frame.
      TX_WAIT: begin
        if (rx_valid) err_inc = 1'b1;
        if (tx_busy) begin
          busy_seen_nxt = 1'b1;
        end else if (busy_seen) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
